sram_req_ctrl: RTL and testbench

SRAM_REQ_CTRL -- requirements
Module: sram_req_ctrl

---
 rtl/sram_ctrl_pkg.sv | 15 +
 rtl/resp_fifo2.sv | 61 ++++++
 rtl/sram_req_ctrl_chk.sv | 21 ++
 rtl/sram_req_ctrl.sv | 126 ++++++++++++
 tb/tb_sram_req_ctrl.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared sizing constants and controller state encoding for the SRAM request
// controller and its response buffer.
package sram_ctrl_pkg;

  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 17;
  localparam logic [DATA_W-1:0] INIT_VAL = 17'd0;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/resp_fifo2.sv
// Two-entry valid/ready response buffer; holds read data until the consumer
// takes it, preserving order.
module resp_fifo2 #(
  parameter int DATA_W = sram_ctrl_pkg::DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        count_o
);

  logic [DATA_W-1:0] mem_q [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              push_s, pop_s;

  assign in_ready_o  = (count_q != 2'd2);
  assign out_valid_o = (count_q != 2'd0);
  assign out_data_o  = mem_q[rd_ptr_q];
  assign count_o     = count_q;

  // Handshakes, pointer wrap and occupancy update
  always_comb begin
    push_s   = in_valid_i & in_ready_o;
    pop_s    = out_valid_o & out_ready_i;
    wr_ptr_d = wr_ptr_q ^ push_s;
    rd_ptr_d = rd_ptr_q ^ pop_s;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only visible after being written
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= in_data_i;
    end
  end

endmodule

// File: rtl/sram_req_ctrl_chk.sv
// Run-time guard for the response buffer: the credit scheme must make a push
// into a full buffer impossible.
module sram_req_ctrl_chk (
  input logic       clk_i,
  input logic       rst_i,
  input logic       push_i,
  input logic       push_ready_i,
  input logic [1:0] count_i
);

  // Flag any push that would overflow the buffer
  always @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(push_i && (count_i == 2'd2)))
        else $error("sram_req_ctrl: response push while buffer holds 2 entries");
      assert (!(push_i && !push_ready_i))
        else $error("sram_req_ctrl: response push while buffer not ready");
    end
  end

endmodule

// File: rtl/sram_req_ctrl.sv
// Request front-end for a single-port SRAM macro: clears the array after reset,
// then decodes requests onto the macro pins and returns read data in order.
module sram_req_ctrl #(
  parameter int                                  DEPTH    = sram_ctrl_pkg::DEPTH,
  parameter int                                  ADDR_W   = sram_ctrl_pkg::ADDR_W,
  parameter int                                  DATA_W   = sram_ctrl_pkg::DATA_W,
  parameter logic [sram_ctrl_pkg::DATA_W-1:0]    INIT_VAL = sram_ctrl_pkg::INIT_VAL
) (
  input  logic              clock,
  input  logic              reset,
  output logic              init_done,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_i,
  output logic              sram_web,
  output logic              sram_oeb,
  output logic              sram_csb,
  input  logic [DATA_W-1:0] sram_o
);

  import sram_ctrl_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
  logic              init_done_q, init_done_d;
  logic              rd_inflight_q, rd_inflight_d;
  logic              fire_s;
  logic [1:0]        fifo_count_s;
  logic [1:0]        credits_s;
  logic              fifo_in_ready_s;

  // Credits count reads still owed to the consumer; only registers feed this
  assign credits_s = {1'b0, rd_inflight_q} + fifo_count_s;
  assign req_ready = (state_q == RUN) && (credits_s < 2'd2);
  assign fire_s    = req_valid & req_ready;
  assign init_done = init_done_q;

  // Next-state, clear-sweep counter and macro pin decode
  always_comb begin
    state_d       = state_q;
    init_cnt_d    = init_cnt_q;
    init_done_d   = init_done_q;
    rd_inflight_d = 1'b0;
    sram_csb      = 1'b1;
    sram_web      = 1'b1;
    sram_oeb      = 1'b1;
    sram_a        = {ADDR_W{1'b0}};
    sram_i        = {DATA_W{1'b0}};
    case (state_q)
      INIT: begin
        sram_csb   = 1'b0;
        sram_web   = 1'b0;
        sram_a     = init_cnt_q;
        sram_i     = INIT_VAL;
        init_cnt_d = init_cnt_q + ADDR_W'(1);
        if (init_cnt_q == LAST_ADDR) begin
          state_d     = RUN;
          init_done_d = 1'b1;
        end else begin
          state_d     = INIT;
        end
      end
      RUN: begin
        sram_csb      = ~fire_s;
        sram_web      = ~(fire_s & req_we);
        sram_oeb      = ~(fire_s & ~req_we);
        sram_a        = req_addr;
        sram_i        = req_wdata;
        rd_inflight_d = fire_s & ~req_we;
      end
      default: begin
        state_d     = INIT;
        init_cnt_d  = {ADDR_W{1'b0}};
        init_done_d = 1'b0;
      end
    endcase
  end

  // Controller state registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= INIT;
      init_cnt_q    <= {ADDR_W{1'b0}};
      init_done_q   <= 1'b0;
      rd_inflight_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      init_done_q   <= init_done_d;
      rd_inflight_q <= rd_inflight_d;
    end
  end

  // Macro output is valid the cycle after the read edge; capture it then
  resp_fifo2 #(
    .DATA_W (DATA_W)
  ) u_resp_fifo (
    .clk_i       (clock),
    .rst_i       (reset),
    .in_valid_i  (rd_inflight_q),
    .in_ready_o  (fifo_in_ready_s),
    .in_data_i   (sram_o),
    .out_valid_o (resp_valid),
    .out_ready_i (resp_ready),
    .out_data_o  (resp_rdata),
    .count_o     (fifo_count_s)
  );

  sram_req_ctrl_chk u_chk (
    .clk_i        (clock),
    .rst_i        (reset),
    .push_i       (rd_inflight_q),
    .push_ready_i (fifo_in_ready_s),
    .count_i      (fifo_count_s)
  );

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Directed bench for sram_req_ctrl paired with a behavioural 1024x17 macro
// with one-cycle read latency and random power-up contents.
module tb_sram_req_ctrl;

  logic        clock;
  logic        reset;
  logic        init_done;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [9:0]  req_addr;
  logic [16:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [16:0] resp_rdata;
  logic [9:0]  sram_a;
  logic [16:0] sram_i;
  logic        sram_web;
  logic        sram_oeb;
  logic        sram_csb;
  logic [16:0] sram_o;

  logic [16:0] mem [0:1023];
  int          n_assert;
  int          n_fail;
  int          sent;
  int          got;
  logic [16:0] exp_q [$];

  sram_req_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .init_done  (init_done),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .sram_a     (sram_a),
    .sram_i     (sram_i),
    .sram_web   (sram_web),
    .sram_oeb   (sram_oeb),
    .sram_csb   (sram_csb),
    .sram_o     (sram_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Macro model: random contents, output register updated only on read edges
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 17'($urandom);
    sram_o = 17'($urandom);
  end

  always @(posedge clock) begin
    if (!sram_csb) begin
      if (!sram_web) mem[sram_a] <= sram_i;
      else if (!sram_oeb) sram_o <= mem[sram_a];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic single_write(input logic [9:0] a, input logic [16:0] d, input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    #1;
    chk({tag, "_csb"}, 32'(sram_csb), 32'd0);
    chk({tag, "_web"}, 32'(sram_web), 32'd0);
    chk({tag, "_a"}, 32'(sram_a), 32'(a));
    chk({tag, "_i"}, 32'(sram_i), 32'(d));
    tick();
    req_valid = 1'b0; req_we = 1'b0;
  endtask

  task automatic single_read(input logic [9:0] a, input logic [16:0] exp, input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a;
    #1;
    chk({tag, "_oeb"}, 32'(sram_oeb), 32'd0);
    chk({tag, "_web"}, 32'(sram_web), 32'd1);
    tick();
    req_valid = 1'b0;
    chk({tag, "_lat1"}, 32'(resp_valid), 32'd0);
    tick();
    chk({tag, "_valid"}, 32'(resp_valid), 32'd1);
    chk({tag, "_data"}, 32'(resp_rdata), 32'(exp));
    tick();
    chk({tag, "_drain"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    n_assert = 0; n_fail = 0;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 10'd0;
    req_wdata = 17'd0; resp_ready = 1'b1;
    tick(); tick();
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_sram_a", 32'(sram_a), 32'd0);

    // Reset in the middle of the clear sweep
    reset = 1'b0;
    repeat (500) tick();
    chk("sweep_a500", 32'(sram_a), 32'd500);
    chk("sweep_csb", 32'(sram_csb), 32'd0);
    chk("sweep_web", 32'(sram_web), 32'd0);
    chk("sweep_oeb", 32'(sram_oeb), 32'd1);
    chk("sweep_i", 32'(sram_i), 32'd0);
    chk("sweep_ready", 32'(req_ready), 32'd0);
    reset = 1'b1;
    tick();
    chk("midsweep_rst_a", 32'(sram_a), 32'd0);
    chk("midsweep_rst_done", 32'(init_done), 32'd0);
    reset = 1'b0;
    repeat (1023) tick();
    chk("init_done_1023", 32'(init_done), 32'd0);
    tick();
    chk("init_done_1024", 32'(init_done), 32'd1);
    chk("run_ready", 32'(req_ready), 32'd1);
    chk("run_idle_csb", 32'(sram_csb), 32'd1);

    single_read(10'd0, 17'd0, "clr0");
    single_read(10'd512, 17'd0, "clr512");
    single_read(10'd1023, 17'd0, "clr1023");

    // Write then read same address back-to-back
    single_write(10'd5, 17'h1ABCD, "wr5");
    single_read(10'd5, 17'h1ABCD, "rd5");

    // Read then write same address back-to-back returns old data
    single_write(10'd7, 17'h00111, "wr7a");
    req_valid = 1'b1; req_we = 1'b0; req_addr = 10'd7;
    tick();
    req_we = 1'b1; req_wdata = 17'h00222;
    tick();
    req_valid = 1'b0; req_we = 1'b0;
    chk("rw_valid", 32'(resp_valid), 32'd1);
    chk("rw_old_data", 32'(resp_rdata), 32'h00111);
    tick();
    single_read(10'd7, 17'h00222, "rd7_new");

    // Back-pressure: three reads with the consumer stalled
    single_write(10'd1, 17'h10001, "wr1");
    single_write(10'd2, 17'h10002, "wr2");
    single_write(10'd3, 17'h10003, "wr3");
    resp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 10'd1;
    tick();
    chk("bp_ready_after1", 32'(req_ready), 32'd1);
    req_addr = 10'd2;
    tick();
    chk("bp_ready_after2", 32'(req_ready), 32'd0);
    chk("bp_valid", 32'(resp_valid), 32'd1);
    chk("bp_head1", 32'(resp_rdata), 32'h10001);
    req_addr = 10'd3;
    repeat (4) tick();
    chk("bp_ready_held", 32'(req_ready), 32'd0);
    chk("bp_head1_held", 32'(resp_rdata), 32'h10001);
    resp_ready = 1'b1;
    tick();
    chk("bp_head2", 32'(resp_rdata), 32'h10002);
    chk("bp_ready_freed", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    chk("bp_empty", 32'(resp_valid), 32'd0);
    tick();
    chk("bp_valid3", 32'(resp_valid), 32'd1);
    chk("bp_head3", 32'(resp_rdata), 32'h10003);
    tick();
    chk("bp_drained", 32'(resp_valid), 32'd0);

    // Streaming reads with random consumer stalls
    for (int i = 0; i < 16; i++) single_write(10'(100 + i), 17'h05000 + 17'(i), "swr");
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 300 && got < 16; cyc++) begin
      resp_ready = ($urandom_range(3) != 0);
      req_valid  = (sent < 16);
      req_we     = 1'b0;
      req_addr   = 10'(100 + sent);
      #1;
      if (req_valid && req_ready) begin
        exp_q.push_back(17'h05000 + 17'(sent));
        sent++;
      end
      if (resp_valid && resp_ready) begin
        chk("stream_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) chk("stream_data", 32'(resp_rdata), 32'(exp_q.pop_front()));
        got++;
      end
      tick();
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    chk("stream_got", 32'(got), 32'd16);
    chk("stream_leftover", 32'(exp_q.size()), 32'd0);
    tick();
    chk("stream_idle", 32'(resp_valid), 32'd0);

    // Reset with two responses buffered
    resp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 10'd5;
    tick();
    req_addr = 10'd7;
    tick();
    req_valid = 1'b0;
    tick();
    chk("buf2_valid", 32'(resp_valid), 32'd1);
    chk("buf2_ready", 32'(req_ready), 32'd0);
    chk("buf2_head", 32'(resp_rdata), 32'h1ABCD);
    reset = 1'b1;
    tick();
    chk("buf2_rst_valid", 32'(resp_valid), 32'd0);
    chk("buf2_rst_ready", 32'(req_ready), 32'd0);
    chk("buf2_rst_a", 32'(sram_a), 32'd0);
    reset = 1'b0; resp_ready = 1'b1;
    tick();
    chk("buf2_sweep_a1", 32'(sram_a), 32'd1);
    chk("buf2_no_stale", 32'(resp_valid), 32'd0);
    repeat (1022) tick();
    chk("buf2_done_1023", 32'(init_done), 32'd0);
    tick();
    chk("buf2_done_1024", 32'(init_done), 32'd1);
    chk("buf2_still_empty", 32'(resp_valid), 32'd0);

    // Top address reachable; earlier data cleared by the new sweep
    single_write(10'd1023, 17'h00001, "wr1023");
    single_read(10'd1023, 17'h00001, "rd1023");
    single_read(10'd5, 17'd0, "rd5_cleared");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
